// File: rtl/slave_bus_pkg.sv
// rtl/slave_bus_pkg.sv - shared types and defaults for the slave bus interface
package slave_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_DONE = 2'd3
   } busState_t;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 8;
   localparam int LEN_W_DEF  = 4;
   localparam int RD_LAT_DEF = 1;

   localparam logic BUS_WR = 1'b1;
   localparam logic BUS_RD = 1'b0;

endpackage

// File: rtl/slave_bus_if_if.sv
// rtl/slave_bus_if_if.sv - master-side command/data bus bundle with master and slave views
interface slave_bus_if_if
   import slave_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
);

   logic              BusReq;
   logic              BusWr;
   logic [ADDR_W-1:0] BusAddr;
   logic [LEN_W-1:0]  BusLen;
   logic [DATA_W-1:0] BusWData;
   logic              BusWValid;
   logic              BusGnt;
   logic              BusBusy;
   logic [DATA_W-1:0] BusRData;
   logic              BusRValid;
   logic              BusDone;

   modport master (
      output BusReq, BusWr, BusAddr, BusLen, BusWData, BusWValid,
      input  BusGnt, BusBusy, BusRData, BusRValid, BusDone
   );

   modport slave (
      input  BusReq, BusWr, BusAddr, BusLen, BusWData, BusWValid,
      output BusGnt, BusBusy, BusRData, BusRValid, BusDone
   );

endinterface

// File: rtl/slave_bus_beat_ctr.sv
// rtl/slave_bus_beat_ctr.sv - loadable wrapping word address plus beat counter with last-beat flag
module slave_bus_beat_ctr
   import slave_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
)
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] startAddr,
   input  logic [LEN_W-1:0]  len,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              lastBeat,
   output logic              exhausted
);

   logic [LEN_W-1:0] beatCnt;
   logic [LEN_W-1:0] lenReg;

   // Once the last beat has stepped, the counter freezes until the next load
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         addr      <= '0;
         beatCnt   <= '0;
         lenReg    <= '0;
         exhausted <= 1'b0;
      end else if (load) begin
         addr      <= startAddr;
         beatCnt   <= '0;
         lenReg    <= len;
         exhausted <= 1'b0;
      end else if (step && !exhausted) begin
         addr <= addr + 1'b1;
         if (lastBeat) begin
            exhausted <= 1'b1;
         end else begin
            beatCnt <= beatCnt + 1'b1;
         end
      end
   end

   assign lastBeat = (beatCnt == lenReg);

endmodule

// File: rtl/slave_bus_if.sv
// rtl/slave_bus_if.sv - turns master burst commands into per-beat strobes for the memory core
module slave_bus_if
   import slave_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
)
(
   input  logic              Clk,
   input  logic              Rst_n,
   slave_bus_if_if.slave     bus,
   output logic [DATA_W-1:0] MemDataIn,
   output logic [ADDR_W-1:0] MemWrAddr,
   output logic              MemWen,
   output logic [ADDR_W-1:0] MemRdAddr,
   output logic              MemRen,
   input  logic [DATA_W-1:0] MemDataOut
);

   busState_t         state;
   busState_t         nextState;
   logic              accept;
   logic              wrBeat;
   logic              rdIssue;
   logic              gntReg;
   logic [ADDR_W-1:0] beatAddr;
   logic              lastBeat;
   logic              exhausted;
   logic [RD_LAT-1:0] vldPipe;
   logic [RD_LAT-1:0] lastPipe;

   assign accept  = (state == ST_IDLE) && bus.BusReq;
   assign wrBeat  = (state == ST_WR) && bus.BusWValid && !exhausted;
   assign rdIssue = (state == ST_RD) && !exhausted;

   slave_bus_beat_ctr #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_beat_ctr (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .load      (accept),
      .startAddr (bus.BusAddr),
      .len       (bus.BusLen),
      .step      (wrBeat || rdIssue),
      .addr      (beatAddr),
      .lastBeat  (lastBeat),
      .exhausted (exhausted)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState   = state;
      bus.BusBusy = (state != ST_IDLE);
      bus.BusDone = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            if (bus.BusReq) begin
               nextState = (bus.BusWr == BUS_WR) ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
            if (wrBeat && lastBeat) begin
               nextState = ST_DONE;
            end
         end
         ST_RD: begin
            if (lastPipe[RD_LAT-1]) begin
               nextState = ST_DONE;
            end
         end
         ST_DONE: nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   // Write beats are registered so the core sees address, data and strobe together
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         MemWen    <= 1'b0;
         MemWrAddr <= '0;
         MemDataIn <= '0;
         gntReg    <= 1'b0;
      end else begin
         MemWen <= wrBeat;
         gntReg <= accept;
         if (wrBeat) begin
            MemWrAddr <= beatAddr;
            MemDataIn <= bus.BusWData;
         end
      end
   end

   // Read-valid delay line; lastPipe marks which returning beat closes the burst
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vldPipe  <= '0;
         lastPipe <= '0;
      end else begin
         vldPipe[0]  <= rdIssue;
         lastPipe[0] <= rdIssue && lastBeat;
         for (int i = 1; i < RD_LAT; i++) begin
            vldPipe[i]  <= vldPipe[i-1];
            lastPipe[i] <= lastPipe[i-1];
         end
      end
   end

   assign MemRen        = rdIssue;
   assign MemRdAddr     = rdIssue ? beatAddr : '0;
   assign bus.BusGnt    = gntReg;
   assign bus.BusRValid = vldPipe[RD_LAT-1];
   assign bus.BusRData  = vldPipe[RD_LAT-1] ? MemDataOut : '0;

endmodule

// File: tb/tb_slave_bus_if.sv
// tb/tb_slave_bus_if.sv - directed self-checking bench for slave_bus_if
module tb_slave_bus_if;

   logic        Clk;
   logic        Rst_n;
   logic [31:0] MemDataIn;
   logic [7:0]  MemWrAddr;
   logic        MemWen;
   logic [7:0]  MemRdAddr;
   logic        MemRen;
   logic [31:0] MemDataOut;

   int errors;
   int checks;
   int cyc;
   int gntCnt, doneCnt, doneCyc, bothCnt;
   int wrAddrQ[$], wrDataQ[$], wenCycQ[$];
   int rdAddrQ[$], renCycQ[$], rdDataQ[$], rvCycQ[$];
   int expQ[$];
   logic [31:0] wdat [16];
   logic [31:0] mem [256];

   slave_bus_if_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(4)) bus ();

   slave_bus_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(4), .RD_LAT(1)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .bus        (bus),
      .MemDataIn  (MemDataIn),
      .MemWrAddr  (MemWrAddr),
      .MemWen     (MemWen),
      .MemRdAddr  (MemRdAddr),
      .MemRen     (MemRen),
      .MemDataOut (MemDataOut)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (MemWen) mem[MemWrAddr] <= MemDataIn;
      if (MemRen) MemDataOut <= mem[MemRdAddr];
   end

   always @(negedge Clk) begin
      if (bus.BusGnt) gntCnt++;
      if (bus.BusDone) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (MemWen && MemRen) bothCnt++;
      if (MemWen) begin
         wrAddrQ.push_back(int'(MemWrAddr));
         wrDataQ.push_back(int'(MemDataIn));
         wenCycQ.push_back(cyc);
      end
      if (MemRen) begin
         rdAddrQ.push_back(int'(MemRdAddr));
         renCycQ.push_back(cyc);
      end
      if (bus.BusRValid) begin
         rdDataQ.push_back(int'(bus.BusRData));
         rvCycQ.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkSeq(input string tag, input int got[$], input int exp[$]);
      chk({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         chk(tag, (i < got.size()) ? got[i] : -1, exp[i]);
      end
   endtask

   task automatic clearMon();
      gntCnt = 0; doneCnt = 0; doneCyc = -1; bothCnt = 0;
      wrAddrQ.delete(); wrDataQ.delete(); wenCycQ.delete();
      rdAddrQ.delete(); renCycQ.delete(); rdDataQ.delete(); rvCycQ.delete();
   endtask

   task automatic cmdIssue(input logic wr, input int addr, input int len);
      bus.BusReq  = 1'b1;
      bus.BusWr   = wr;
      bus.BusAddr = addr[7:0];
      bus.BusLen  = len[3:0];
      @(posedge Clk); #1;
      bus.BusReq  = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (bus.BusBusy && n < 60) begin
         @(posedge Clk); #1;
         n++;
      end
      chk({tag, "_timeout"}, (n < 60) ? 1 : 0, 1);
   endtask

   task automatic doWrite(input int addr, input int len, input logic [7:0] vpat, input int npat);
      int beat;
      beat = 0;
      cmdIssue(1'b1, addr, len);
      for (int i = 0; i < npat; i++) begin
         bus.BusWValid = vpat[i];
         bus.BusWData  = vpat[i] ? wdat[beat] : 32'hDEAD;
         if (vpat[i]) beat++;
         @(posedge Clk); #1;
      end
      bus.BusWValid = 1'b0;
      waitIdle("wr");
   endtask

   task automatic doRead(input int addr, input int len);
      cmdIssue(1'b0, addr, len);
      waitIdle("rd");
   endtask

   initial begin
      int n;
      errors = 0; checks = 0; cyc = 0;
      MemDataOut = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.BusReq = 1'b0; bus.BusWr = 1'b0; bus.BusAddr = '0; bus.BusLen = '0;
      bus.BusWData = '0; bus.BusWValid = 1'b0;
      clearMon();
      Rst_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_outs", |{bus.BusGnt, bus.BusBusy, bus.BusRValid, bus.BusDone, bus.BusRData,
                        MemWen, MemRen, MemWrAddr, MemDataIn, MemRdAddr}, 0);
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      chk("rst_idle_busy", bus.BusBusy, 0);

      // single write then single read of address 22
      clearMon();
      wdat[0] = 100;
      doWrite(22, 0, 8'b1, 1);
      expQ.delete(); expQ.push_back(22);  chkSeq("w1_addr", wrAddrQ, expQ);
      expQ.delete(); expQ.push_back(100); chkSeq("w1_data", wrDataQ, expQ);
      chk("w1_gnt", gntCnt, 1);
      chk("w1_done", doneCnt, 1);

      clearMon();
      doRead(22, 0);
      expQ.delete(); expQ.push_back(22);  chkSeq("r1_addr", rdAddrQ, expQ);
      expQ.delete(); expQ.push_back(100); chkSeq("r1_data", rdDataQ, expQ);
      chk("r1_lat", (rvCycQ.size() > 0 && renCycQ.size() > 0) ? rvCycQ[0] - renCycQ[0] : -1, 1);
      chk("r1_gnt", gntCnt, 1);
      chk("r1_done", doneCnt, 1);
      chk("r1_done_after", (rvCycQ.size() > 0) ? doneCyc - rvCycQ[0] : -1, 1);

      // wrapping burst at 254
      clearMon();
      wdat[0] = 1; wdat[1] = 2; wdat[2] = 3; wdat[3] = 4;
      doWrite(254, 3, 8'b1111, 4);
      expQ.delete(); expQ.push_back(254); expQ.push_back(255); expQ.push_back(0); expQ.push_back(1);
      chkSeq("wrap_waddr", wrAddrQ, expQ);
      expQ.delete(); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3); expQ.push_back(4);
      chkSeq("wrap_wdata", wrDataQ, expQ);
      chk("wrap_wdone", doneCnt, 1);

      clearMon();
      doRead(254, 3);
      expQ.delete(); expQ.push_back(254); expQ.push_back(255); expQ.push_back(0); expQ.push_back(1);
      chkSeq("wrap_raddr", rdAddrQ, expQ);
      expQ.delete(); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3); expQ.push_back(4);
      chkSeq("wrap_rdata", rdDataQ, expQ);
      chk("wrap_rconsec", (rvCycQ.size() == 4) ? rvCycQ[3] - rvCycQ[0] : -1, 3);
      chk("wrap_rdone", doneCnt, 1);

      // stalled write: valid pattern 1,0,0,1,1
      clearMon();
      wdat[0] = 7; wdat[1] = 8; wdat[2] = 9;
      doWrite(10, 2, 8'b11001, 5);
      expQ.delete(); expQ.push_back(10); expQ.push_back(11); expQ.push_back(12);
      chkSeq("stall_addr", wrAddrQ, expQ);
      expQ.delete(); expQ.push_back(7); expQ.push_back(8); expQ.push_back(9);
      chkSeq("stall_data", wrDataQ, expQ);
      chk("stall_done", doneCnt, 1);
      chk("stall_done_cyc", (wenCycQ.size() == 3) ? doneCyc - wenCycQ[2] : -1, 0);

      // requests during an active read and during DONE are ignored
      clearMon();
      cmdIssue(1'b0, 254, 3);
      @(posedge Clk); #1;
      bus.BusReq = 1'b1; bus.BusWr = 1'b1; bus.BusAddr = 8'd99; bus.BusLen = 4'd0;
      @(posedge Clk); #1;
      bus.BusReq = 1'b0;
      n = 0;
      while (!bus.BusDone && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      chk("ign_done_seen", bus.BusDone, 1);
      bus.BusReq = 1'b1;
      @(posedge Clk); #1;
      bus.BusReq = 1'b0;
      chk("ign_idle_busy", bus.BusBusy, 0);
      chk("ign_idle_gnt", bus.BusGnt, 0);
      @(posedge Clk); #1;
      chk("ign_gnt", gntCnt, 1);
      chk("ign_wen", wrAddrQ.size(), 0);
      expQ.delete(); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3); expQ.push_back(4);
      chkSeq("ign_rdata", rdDataQ, expQ);
      chk("ign_done", doneCnt, 1);

      // reset in the middle of a 4-beat write
      clearMon();
      cmdIssue(1'b1, 40, 3);
      bus.BusWValid = 1'b1; bus.BusWData = 11;
      @(posedge Clk); #1;
      bus.BusWData = 12;
      chk("abort_wen_pre", MemWen, 1);
      #2;
      Rst_n = 1'b0;
      #1;
      chk("abort_outs", |{bus.BusGnt, bus.BusBusy, bus.BusRValid, bus.BusDone, bus.BusRData,
                          MemWen, MemRen, MemWrAddr, MemDataIn, MemRdAddr}, 0);
      bus.BusWValid = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      chk("abort_no_done", doneCnt, 0);
      chk("abort_no_wen", wrAddrQ.size(), 0);
      chk("abort_busy", bus.BusBusy, 0);

      clearMon();
      wdat[0] = 21; wdat[1] = 22;
      doWrite(40, 1, 8'b11, 2);
      expQ.delete(); expQ.push_back(40); expQ.push_back(41); chkSeq("post_waddr", wrAddrQ, expQ);
      expQ.delete(); expQ.push_back(21); expQ.push_back(22); chkSeq("post_wdata", wrDataQ, expQ);
      chk("post_wdone", doneCnt, 1);
      clearMon();
      doRead(40, 1);
      expQ.delete(); expQ.push_back(21); expQ.push_back(22); chkSeq("post_rdata", rdDataQ, expQ);
      chk("post_rdone", doneCnt, 1);
      chk("no_wen_ren_overlap", bothCnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
